// File: rtl/shift_sequencer_pkg.sv
// Shared constants for the iterative shift sequencer: FSM state encoding and
// the Shift_Unit function codes it drives on SU_ALU_FUN.
package shift_seq_pkg;

  localparam int STATE_W = 2;
  localparam int FUN_W   = 2;

  localparam logic [STATE_W-1:0] IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] DONE  = 2'd3;

  localparam logic [FUN_W-1:0] SHR_A = 2'b00;
  localparam logic [FUN_W-1:0] SHL_A = 2'b01;
  localparam logic [FUN_W-1:0] SHR_B = 2'b10;
  localparam logic [FUN_W-1:0] SHL_B = 2'b11;

endpackage

// File: rtl/shift_sequencer_if.sv
// Request/result handshake plus the Shift_Unit drive/return lines of the
// shift sequencer, bundled so the parent wires one port.
interface shift_sequencer_if #(
  parameter int Width     = 16,
  parameter int Amt_Width = 5
) ();
  import shift_seq_pkg::*;

  logic                 Req_Valid;
  logic                 Req_Ready;
  logic [Width-1:0]     Req_Data;
  logic                 Req_Dir;
  logic [Amt_Width-1:0] Req_Amount;
  logic                 Abort;
  logic                 Res_Valid;
  logic                 Res_Ready;
  logic [Width-1:0]     Res_Data;
  logic                 Busy;
  logic [Width-1:0]     SU_A;
  logic [Width-1:0]     SU_B;
  logic [FUN_W-1:0]     SU_ALU_FUN;
  logic                 SU_Enable;
  logic [Width-1:0]     SU_OUT;
  logic                 SU_Flag;

  // master: the surroundings (request source, result sink, Shift_Unit side)
  modport master (
    output Req_Valid, Req_Data, Req_Dir, Req_Amount, Abort, Res_Ready,
           SU_OUT, SU_Flag,
    input  Req_Ready, Res_Valid, Res_Data, Busy, SU_A, SU_B, SU_ALU_FUN,
           SU_Enable
  );

  // slave: the sequencer itself
  modport slave (
    input  Req_Valid, Req_Data, Req_Dir, Req_Amount, Abort, Res_Ready,
           SU_OUT, SU_Flag,
    output Req_Ready, Res_Valid, Res_Data, Busy, SU_A, SU_B, SU_ALU_FUN,
           SU_Enable
  );

endinterface

// File: rtl/shift_sequencer.sv
// Multi-bit logical shifter that steps an external 1-bit registered Shift_Unit
// once per ISSUE/WAIT pair; operand always goes through the A path.
module shift_sequencer
  import shift_seq_pkg::*;
#(
  parameter int Width     = 16,
  parameter int Amt_Width = 5
) (
  input  logic              CLK,
  input  logic              RST,
  shift_sequencer_if.slave  bus
);

  localparam logic [Amt_Width-1:0] AMT_ZERO  = '0;
  localparam logic [Amt_Width-1:0] AMT_ONE   = Amt_Width'(1);
  localparam logic [Amt_Width-1:0] WIDTH_AMT = Amt_Width'(Width);

  logic [STATE_W-1:0]   state_reg,     state_next;
  logic [Width-1:0]     work_reg,      work_next;
  logic                 dir_reg,       dir_next;
  logic [Amt_Width-1:0] count_reg,     count_next;
  logic [Width-1:0]     res_data_reg,  res_data_next;
  logic                 res_valid_reg, res_valid_next;
  logic                 su_enable_reg, su_enable_next;
  logic [Width-1:0]     su_a_reg,      su_a_next;
  logic [FUN_W-1:0]     su_fun_reg,    su_fun_next;

  always_comb begin
    state_next     = state_reg;
    work_next      = work_reg;
    dir_next       = dir_reg;
    count_next     = count_reg;
    res_data_next  = res_data_reg;
    res_valid_next = res_valid_reg;
    su_enable_next = su_enable_reg;
    su_a_next      = su_a_reg;
    su_fun_next    = su_fun_reg;

    // Abort wins over every other transition, including an IDLE accept.
    if (bus.Abort) begin
      state_next     = IDLE;
      res_valid_next = 1'b0;
      su_enable_next = 1'b0;
      su_a_next      = '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.Req_Valid) begin
            work_next  = bus.Req_Data;
            dir_next   = bus.Req_Dir;
            count_next = bus.Req_Amount;
            if (bus.Req_Amount == AMT_ZERO) begin
              state_next     = DONE;
              res_data_next  = bus.Req_Data;
              res_valid_next = 1'b1;
            end else if (bus.Req_Amount >= WIDTH_AMT) begin
              state_next     = DONE;
              res_data_next  = '0;
              res_valid_next = 1'b1;
            end else begin
              // Outputs are registered, so the first ISSUE drive is set up here.
              state_next     = ISSUE;
              su_enable_next = 1'b1;
              su_a_next      = bus.Req_Data;
              su_fun_next    = bus.Req_Dir ? SHL_A : SHR_A;
            end
          end
        end

        ISSUE: begin
          state_next     = WAIT;
          su_enable_next = 1'b1;
          su_a_next      = work_reg;
          su_fun_next    = dir_reg ? SHL_A : SHR_A;
        end

        WAIT: begin
          if (bus.SU_Flag) begin
            work_next  = bus.SU_OUT;
            count_next = count_reg - AMT_ONE;
            if (count_reg == AMT_ONE) begin
              state_next     = DONE;
              res_data_next  = bus.SU_OUT;
              res_valid_next = 1'b1;
              su_enable_next = 1'b0;
              su_a_next      = '0;
            end else begin
              state_next = ISSUE;
              su_a_next  = bus.SU_OUT;
            end
          end
        end

        DONE: begin
          if (bus.Res_Ready) begin
            state_next     = IDLE;
            res_valid_next = 1'b0;
          end
        end

        default: begin
          state_next     = IDLE;
          res_valid_next = 1'b0;
          su_enable_next = 1'b0;
          su_a_next      = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      dir_reg       <= 1'b0;
      count_reg     <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      su_enable_reg <= 1'b0;
      su_a_reg      <= '0;
      su_fun_reg    <= SHR_A;
    end else begin
      state_reg     <= state_next;
      work_reg      <= work_next;
      dir_reg       <= dir_next;
      count_reg     <= count_next;
      res_data_reg  <= res_data_next;
      res_valid_reg <= res_valid_next;
      su_enable_reg <= su_enable_next;
      su_a_reg      <= su_a_next;
      su_fun_reg    <= su_fun_next;
    end
  end

  assign bus.Req_Ready  = (state_reg == IDLE);
  assign bus.Busy       = (state_reg != IDLE);
  assign bus.Res_Valid  = res_valid_reg;
  assign bus.Res_Data   = res_data_reg;
  assign bus.SU_A       = su_a_reg;
  assign bus.SU_B       = '0;
  assign bus.SU_ALU_FUN = su_fun_reg;
  assign bus.SU_Enable  = su_enable_reg;

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer, with a behavioural 1-bit registered
// Shift_Unit attached to the SU_* lines.
module tb_shift_sequencer;
  import shift_seq_pkg::*;

  localparam int W  = 16;
  localparam int AW = 5;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  shift_sequencer_if #(.Width(W), .Amt_Width(AW)) bus ();

  shift_sequencer #(.Width(W), .Amt_Width(AW)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  // Shift_Unit stand-in: its active-low reset is ~RST.
  logic [W-1:0] su_out_reg;
  logic         su_flag_reg;
  always @(posedge CLK) begin
    if (!(~RST)) begin
      su_out_reg  <= '0;
      su_flag_reg <= 1'b0;
    end else if (bus.SU_Enable) begin
      case (bus.SU_ALU_FUN)
        2'b00:   su_out_reg <= bus.SU_A >> 1;
        2'b01:   su_out_reg <= bus.SU_A << 1;
        2'b10:   su_out_reg <= bus.SU_B >> 1;
        default: su_out_reg <= bus.SU_B << 1;
      endcase
      su_flag_reg <= 1'b1;
    end else begin
      su_flag_reg <= 1'b0;
    end
  end
  assign bus.SU_OUT  = su_out_reg;
  assign bus.SU_Flag = su_flag_reg;

  typedef struct {
    logic [W-1:0] data;
    int           lat;
    int           acc;
  } sb_t;

  sb_t exp_q[$];
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  en_total = 0;
  int  shl_total = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  always @(negedge CLK) begin
    if (bus.SU_Enable) begin
      en_total <= en_total + 1;
      if (bus.SU_ALU_FUN == SHL_A) shl_total <= shl_total + 1;
    end
  end

  function automatic logic [W-1:0] model_shift(input logic [W-1:0] d, input logic dir, input int amt);
    if (amt >= W) return '0;
    return dir ? (d << amt) : (d >> amt);
  endfunction

  // Cycle 1 is the cycle right after the accept edge.
  function automatic int model_lat(input int amt);
    return (amt == 0 || amt >= W) ? 1 : 2 * amt + 1;
  endfunction

  task automatic send_req(input logic [W-1:0] d, input logic dir, input logic [AW-1:0] amt);
    sb_t e;
    bit  ok;
    ok = 1'b0;
    bus.Req_Valid  = 1'b1;
    bus.Req_Data   = d;
    bus.Req_Dir    = dir;
    bus.Req_Amount = amt;
    for (int i = 0; i < 200; i++) begin
      if (bus.Req_Ready) begin
        @(posedge CLK); #1;
        ok = 1'b1;
        break;
      end
      @(posedge CLK); #1;
    end
    bus.Req_Valid = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL accept_timeout: got no Req_Ready required accept within 200 cycles");
    end
    e.data = model_shift(d, dir, int'(amt));
    e.lat  = model_lat(int'(amt));
    e.acc  = cyc;
    exp_q.push_back(e);
    $display("req  data=%h dir=%0d amt=%0d accepted_cyc=%0d", d, dir, amt, cyc);
  endtask

  task automatic wait_valid(output bit found, output int vcyc);
    found = 1'b0;
    vcyc  = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.Res_Valid) begin
        found = 1'b1;
        vcyc  = cyc;
        break;
      end
      @(posedge CLK); #1;
    end
    if (found) $display("res  data=%h valid_cyc=%0d", bus.Res_Data, vcyc);
  endtask

  task automatic consume();
    bus.Res_Ready = 1'b1;
    @(posedge CLK); #1;
    bus.Res_Ready = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checks++;
    if ({bus.Busy, bus.Req_Ready, bus.Res_Valid, bus.SU_Enable, bus.SU_ALU_FUN} !== 6'b010000) begin
      failures++;
      $display("FAIL reset_ctrl: got %b required 010000", {bus.Busy, bus.Req_Ready, bus.Res_Valid, bus.SU_Enable, bus.SU_ALU_FUN});
    end
    checks++;
    if (bus.SU_A !== 16'h0 || bus.Res_Data !== 16'h0 || bus.SU_B !== 16'h0) begin
      failures++;
      $display("FAIL reset_data: got SU_A=%h Res_Data=%h SU_B=%h required all 0000", bus.SU_A, bus.Res_Data, bus.SU_B);
    end
    RST = 1'b0;
    @(posedge CLK); #1;
    checks++;
    if (bus.Req_Ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: got %b required 1", bus.Req_Ready);
    end
  endtask

  task automatic test_right_shift();
    int en0, shl0, vcyc;
    bit found;
    sb_t e;
    logic [W-1:0] got;
    en0 = en_total; shl0 = shl_total;
    send_req(16'hF0F0, 1'b0, 5'd3);
    wait_valid(found, vcyc);
    got = bus.Res_Data;
    e = exp_q.pop_front();
    consume();
    checks++;
    if (!found) begin failures++; $display("FAIL right_timeout: got no Res_Valid required one"); end
    checks++;
    if (got !== 16'h1E1E || got !== e.data) begin
      failures++; $display("FAIL right_data: got %h required %h", got, e.data);
    end
    checks++;
    if (vcyc - e.acc + 1 != e.lat) begin
      failures++; $display("FAIL right_latency: got %0d required %0d", vcyc - e.acc + 1, e.lat);
    end
    checks++;
    if (en_total - en0 != 6) begin
      failures++; $display("FAIL right_enable_cycles: got %0d required 6", en_total - en0);
    end
    checks++;
    if (shl_total - shl0 != 0) begin
      failures++; $display("FAIL right_fun: got %0d left-shift cycles required 0", shl_total - shl0);
    end
  endtask

  task automatic test_left_shift();
    int en0, shl0, vcyc;
    bit found;
    sb_t e;
    logic [W-1:0] got;
    en0 = en_total; shl0 = shl_total;
    send_req(16'h8001, 1'b1, 5'd4);
    wait_valid(found, vcyc);
    got = bus.Res_Data;
    e = exp_q.pop_front();
    consume();
    checks++;
    if (!found || got !== 16'h0010 || got !== e.data) begin
      failures++; $display("FAIL left_data: got %h found=%0d required %h", got, found, e.data);
    end
    checks++;
    if (vcyc - e.acc + 1 != 9) begin
      failures++; $display("FAIL left_latency: got %0d required 9", vcyc - e.acc + 1);
    end
    checks++;
    if (en_total - en0 != 8 || shl_total - shl0 != 8) begin
      failures++; $display("FAIL left_fun: got en=%0d shl=%0d required 8 and 8", en_total - en0, shl_total - shl0);
    end
  endtask

  task automatic test_boundaries();
    int en0, vcyc;
    bit found;
    sb_t e;
    logic [W-1:0] got;
    en0 = en_total;
    send_req(16'hABCD, 1'b0, 5'd0);
    wait_valid(found, vcyc);
    got = bus.Res_Data;
    e = exp_q.pop_front();
    consume();
    checks++;
    if (!found || got !== 16'hABCD || vcyc - e.acc + 1 != 1) begin
      failures++; $display("FAIL zero_amount: got %h lat=%0d required ABCD lat=1", got, vcyc - e.acc + 1);
    end
    @(posedge CLK); #1;
    send_req(16'hFFFF, 1'b1, 5'd20);
    wait_valid(found, vcyc);
    got = bus.Res_Data;
    e = exp_q.pop_front();
    consume();
    checks++;
    if (!found || got !== 16'h0000 || vcyc - e.acc + 1 != 1) begin
      failures++; $display("FAIL saturate_amount: got %h lat=%0d required 0000 lat=1", got, vcyc - e.acc + 1);
    end
    checks++;
    if (en_total - en0 != 0) begin
      failures++; $display("FAIL boundary_enable: got %0d enable cycles required 0", en_total - en0);
    end
    @(posedge CLK); #1;
  endtask

  task automatic test_backpressure();
    int vcyc, bad;
    bit found;
    sb_t e;
    send_req(16'h1234, 1'b1, 5'd2);
    wait_valid(found, vcyc);
    e = exp_q.pop_front();
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.Res_Valid !== 1'b1 || bus.Res_Data !== e.data || bus.Req_Ready !== 1'b0) bad++;
      @(posedge CLK); #1;
    end
    checks++;
    if (!found || bad != 0) begin
      failures++; $display("FAIL bp_stable: got %0d unstable cycles found=%0d required 0", bad, found);
    end
    checks++;
    if (bus.Res_Data !== 16'h48D0) begin
      failures++; $display("FAIL bp_data: got %h required 48d0", bus.Res_Data);
    end
    consume();
    checks++;
    if (bus.Busy !== 1'b0 || bus.Res_Valid !== 1'b0 || bus.Req_Ready !== 1'b1) begin
      failures++; $display("FAIL bp_release: got busy=%b valid=%b ready=%b required 0 0 1", bus.Busy, bus.Res_Valid, bus.Req_Ready);
    end
  endtask

  task automatic test_abort();
    sb_t e;
    int seen;
    send_req(16'hFFFF, 1'b0, 5'd5);
    repeat (3) begin @(posedge CLK); #1; end
    checks++;
    if (bus.Busy !== 1'b1 || bus.SU_Enable !== 1'b1) begin
      failures++; $display("FAIL abort_midop: got busy=%b en=%b required 1 1", bus.Busy, bus.SU_Enable);
    end
    bus.Abort = 1'b1;
    @(posedge CLK); #1;
    bus.Abort = 1'b0;
    e = exp_q.pop_back();
    checks++;
    if (bus.Busy !== 1'b0 || bus.Res_Valid !== 1'b0 || bus.SU_Enable !== 1'b0 || bus.SU_A !== 16'h0) begin
      failures++; $display("FAIL abort_idle: got busy=%b valid=%b en=%b a=%h required 0 0 0 0000", bus.Busy, bus.Res_Valid, bus.SU_Enable, bus.SU_A);
    end
    seen = 0;
    repeat (20) begin
      if (bus.Res_Valid) seen++;
      @(posedge CLK); #1;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL abort_no_result: got %0d valid cycles required 0", seen); end
    bus.Req_Valid = 1'b1; bus.Req_Amount = 5'd2; bus.Abort = 1'b1;
    @(posedge CLK); #1;
    bus.Req_Valid = 1'b0; bus.Abort = 1'b0;
    checks++;
    if (bus.Busy !== 1'b0) begin failures++; $display("FAIL abort_in_idle: got busy=%b required 0", bus.Busy); end
    $display("abort dropped request data=%h", e.data);
  endtask

  task automatic test_reset_midop();
    sb_t e;
    int seen;
    send_req(16'h00FF, 1'b1, 5'd5);
    repeat (3) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    e = exp_q.pop_back();
    checks++;
    if ({bus.Busy, bus.Req_Ready, bus.Res_Valid, bus.SU_Enable, bus.SU_ALU_FUN} !== 6'b010000 ||
        bus.SU_A !== 16'h0 || bus.Res_Data !== 16'h0) begin
      failures++;
      $display("FAIL reset_midop: got ctrl=%b a=%h res=%h required 010000 0000 0000",
               {bus.Busy, bus.Req_Ready, bus.Res_Valid, bus.SU_Enable, bus.SU_ALU_FUN}, bus.SU_A, bus.Res_Data);
    end
    RST = 1'b0;
    seen = 0;
    repeat (12) begin
      if (bus.Res_Valid) seen++;
      @(posedge CLK); #1;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL reset_no_result: got %0d valid cycles required 0", seen); end
    $display("reset dropped request data=%h", e.data);
  endtask

  task automatic test_back_to_back();
    sb_t r1, r2;
    logic [W-1:0] g1, g2;
    int v1, v2;
    bit f1, f2;
    fork
      begin
        send_req(16'h0F0F, 1'b0, 5'd1);
        send_req(16'h0001, 1'b1, 5'd15);
      end
      begin
        wait_valid(f1, v1);
        g1 = bus.Res_Data;
        r1 = exp_q.pop_front();
        consume();
        wait_valid(f2, v2);
        g2 = bus.Res_Data;
        r2 = exp_q.pop_front();
        consume();
      end
    join
    checks++;
    if (!f1 || g1 !== 16'h0787 || g1 !== r1.data) begin
      failures++; $display("FAIL b2b_first: got %h required %h", g1, r1.data);
    end
    checks++;
    if (!f2 || g2 !== 16'h8000 || g2 !== r2.data) begin
      failures++; $display("FAIL b2b_second: got %h required %h", g2, r2.data);
    end
    checks++;
    if (v1 - r1.acc + 1 != r1.lat || v2 - r2.acc + 1 != r2.lat) begin
      failures++; $display("FAIL b2b_latency: got %0d,%0d required %0d,%0d", v1 - r1.acc + 1, v2 - r2.acc + 1, r1.lat, r2.lat);
    end
    checks++;
    if (r2.acc - r1.acc != r1.lat + 1) begin
      failures++; $display("FAIL b2b_gap: got accept spacing %0d required %0d", r2.acc - r1.acc, r1.lat + 1);
    end
  endtask

  initial begin
    bus.Req_Valid  = 1'b0;
    bus.Req_Data   = '0;
    bus.Req_Dir    = 1'b0;
    bus.Req_Amount = '0;
    bus.Abort      = 1'b0;
    bus.Res_Ready  = 1'b0;
    test_reset();
    test_right_shift();
    test_left_shift();
    test_boundaries();
    test_backpressure();
    test_abort();
    test_reset_midop();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion required finish within 200000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule
